// File: rtl/split_radio_scheduler.sv
// ----------------------------------------------------------------------------
// split_radio_scheduler
//
// Shares one receive chain between two consumers: the radio consumer on the
// plus leg and the wire consumer on the minus leg. One consumer at a time is
// granted the chain, with round-robin on ties. The block then captures one
// Receive sample and walks a one-hot enable through the fetch stage and the
// temp stages. The result is delivered on the granted leg with valid/ready.
// The minus (wire) leg carries the bitwise inverse of the sample.
//
// Parameters:
//   STAGES  - temp stages per leg, excluding the input fetch stage (>= 1)
//   DATA_W  - sample width
//   TIMEOUT - delivery wait limit in cycles (>= 1), timeout build only
//
// Ports:
//   Clock, Reset_N         - rising-edge clock, synchronous active-low reset
//   RadioReq, WireReq      - one-sample requests from each consumer
//   Receive                - front-end sample
//   ChainEn                - one-hot stage enable (bit 0 = fetch, bit k = temp k)
//   LegSel                 - 0 = plus/radio leg, 1 = minus/wire leg
//   RadioValid/Data/Ready  - radio delivery handshake
//   WireValid/Data/Ready   - wire delivery handshake
//   Busy                   - controller is not idle
//   Dropped                - one-cycle pulse when a stalled delivery is abandoned
//
// Build option: define SPLIT_RADIO_TIMEOUT_EN to abandon a delivery after
// TIMEOUT cycles without Ready. Without it, DELIVER waits indefinitely and
// Dropped is tied low.
// ----------------------------------------------------------------------------
module split_radio_scheduler #(
    parameter int STAGES  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              RadioReq,
    input  logic              WireReq,
    input  logic [DATA_W-1:0] Receive,
    output logic [STAGES:0]   ChainEn,
    output logic              LegSel,
    output logic              RadioValid,
    output logic [DATA_W-1:0] RadioData,
    input  logic              RadioReady,
    output logic              WireValid,
    output logic [DATA_W-1:0] WireData,
    input  logic              WireReady,
    output logic              Busy,
    output logic              Dropped
);

    if (STAGES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("split_radio_scheduler: STAGES and TIMEOUT must be >= 1");
    end

    localparam int CNT_W = $clog2(STAGES + 1);
    localparam logic [STAGES:0] EN_FETCH = (STAGES + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PROPAGATE,
        DELIVER
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  stage_cnt;
    logic [DATA_W-1:0] sample;
    logic              last_grant;   // leg served last: 0 = radio, 1 = wire
    logic              any_req;
    logic              grant;
    logic              transfer;

    // On a tie the leg that was not served last wins; otherwise whoever asks.
    always_comb begin
        any_req  = RadioReq | WireReq;
        grant    = (RadioReq && WireReq) ? ~last_grant : WireReq;
        transfer = (RadioValid && RadioReady) || (WireValid && WireReady);
    end

    // Busy is decoded straight from the state register, so it is still a
    // registered output with no path from the request or ready inputs.
    assign Busy = (state != IDLE);

`ifdef SPLIT_RADIO_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    // Fires in the stall cycle that would take the counter to TIMEOUT; a
    // Ready in that same cycle is a transfer and takes priority.
    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign Dropped = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            // NOTE: the sample register is cleared on reset as well. It holds
            // a single word, and this keeps the delivered data deterministic.
            state      <= IDLE;
            stage_cnt  <= '0;
            sample     <= '0;
            last_grant <= 1'b1;
            ChainEn    <= '0;
            LegSel     <= 1'b0;
            RadioValid <= 1'b0;
            RadioData  <= '0;
            WireValid  <= 1'b0;
            WireData   <= '0;
`ifdef SPLIT_RADIO_TIMEOUT_EN
            wait_cnt   <= '0;
            Dropped    <= 1'b0;
`endif
        end else begin
`ifdef SPLIT_RADIO_TIMEOUT_EN
            Dropped <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        LegSel  <= grant;
                        ChainEn <= EN_FETCH;
                        state   <= FETCH;
                    end
                end

                FETCH: begin
                    sample    <= Receive;
                    stage_cnt <= CNT_W'(1);
                    ChainEn   <= ChainEn << 1;
                    state     <= PROPAGATE;
                end

                PROPAGATE: begin
                    if (stage_cnt == CNT_W'(STAGES)) begin
                        ChainEn <= '0;
                        state   <= DELIVER;
`ifdef SPLIT_RADIO_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (LegSel) begin
                            WireValid <= 1'b1;
                            WireData  <= ~sample;
                        end else begin
                            RadioValid <= 1'b1;
                            RadioData  <= sample;
                        end
                    end else begin
                        stage_cnt <= stage_cnt + CNT_W'(1);
                        ChainEn   <= ChainEn << 1;
                    end
                end

                DELIVER: begin
                    if (transfer) begin
                        RadioValid <= 1'b0;
                        RadioData  <= '0;
                        WireValid  <= 1'b0;
                        WireData   <= '0;
                        last_grant <= LegSel;
                        state      <= IDLE;
                    end
`ifdef SPLIT_RADIO_TIMEOUT_EN
                    else if (timeout_hit) begin
                        // Abandon the stalled leg; it counts as served so
                        // the other leg wins the next tie.
                        RadioValid <= 1'b0;
                        RadioData  <= '0;
                        WireValid  <= 1'b0;
                        WireData   <= '0;
                        last_grant <= LegSel;
                        Dropped    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_radio_scheduler.sv
// ----------------------------------------------------------------------------
// tb_split_radio_scheduler
//
// Self-checking bench for split_radio_scheduler (STAGES=3, DATA_W=8,
// TIMEOUT=15). Each expected delivery (leg + data) is queued when its request
// is driven. A negedge monitor pops and compares on every valid/ready
// transfer. Per-cycle timing (ChainEn walk, Valid windows, Busy, Dropped) is
// checked inline against cycle numbers counted from the request.
// ----------------------------------------------------------------------------
module tb_split_radio_scheduler;

    localparam int STAGES  = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              Clock = 1'b0;
    logic              Reset_N;
    logic              RadioReq;
    logic              WireReq;
    logic [DATA_W-1:0] Receive;
    logic [STAGES:0]   ChainEn;
    logic              LegSel;
    logic              RadioValid;
    logic [DATA_W-1:0] RadioData;
    logic              RadioReady;
    logic              WireValid;
    logic [DATA_W-1:0] WireData;
    logic              WireReady;
    logic              Busy;
    logic              Dropped;

    split_radio_scheduler #(
        .STAGES (STAGES),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset_N   (Reset_N),
        .RadioReq  (RadioReq),
        .WireReq   (WireReq),
        .Receive   (Receive),
        .ChainEn   (ChainEn),
        .LegSel    (LegSel),
        .RadioValid(RadioValid),
        .RadioData (RadioData),
        .RadioReady(RadioReady),
        .WireValid (WireValid),
        .WireData  (WireData),
        .WireReady (WireReady),
        .Busy      (Busy),
        .Dropped   (Dropped)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic              leg;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic model_last = 1'b1;   // bench's own round-robin pointer

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; outputs are settled here.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic leg, input logic [DATA_W-1:0] d);
        exp_t e;
        e.leg  = leg;
        e.data = leg ? ~d : d;
        sb.push_back(e);
        model_last = leg;
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        step();
        step();
        Reset_N = 1'b1;
        step();
        model_last = 1'b1;
    endtask

    // Transfer monitor: sampled mid-cycle, away from the active edge.
    always @(negedge Clock) begin
        if (Reset_N) begin
            check("valid_exclusive", 32'(RadioValid & WireValid), 0);
            if ((RadioValid && RadioReady) || (WireValid && WireReady)) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("xfer_leg", 32'(WireValid), 32'(e.leg));
                    check("xfer_data", 32'(WireValid ? WireData : RadioData), 32'(e.data));
                    check("idle_leg_data", 32'(WireValid ? RadioData : WireData), 0);
                end
            end
`ifndef SPLIT_RADIO_TIMEOUT_EN
            check("dropped_tied", 32'(Dropped), 0);
`endif
        end
    end

    // One request on one leg with Ready held high; cycle 0 is the request.
    task automatic run_single(input logic leg, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] dn;
        dn = ~d;
        push_exp(leg, d);
        RadioReady = 1'b1;
        WireReady  = 1'b1;
        Receive    = d;
        RadioReq   = ~leg;
        WireReq    = leg;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                RadioReq = 1'b0;
                WireReq  = 1'b0;
            end
            check("chain_en", 32'(ChainEn), (c <= 4) ? (1 << (c - 1)) : 0);
            check("busy", 32'(Busy), 32'(c <= 5));
            if (c <= 5) check("leg_sel", 32'(LegSel), 32'(leg));
            check("radio_valid", 32'(RadioValid), 32'(c == 5 && !leg));
            check("wire_valid", 32'(WireValid), 32'(c == 5 && leg));
            check("radio_data", 32'(RadioData), (c == 5 && !leg) ? 32'(d) : 0);
            check("wire_data", 32'(WireData), (c == 5 && leg) ? 32'(dn) : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              legs [3];
        logic [DATA_W-1:0] d;

        Reset_N    = 1'b0;
        RadioReq   = 1'b0;
        WireReq    = 1'b0;
        RadioReady = 1'b0;
        WireReady  = 1'b0;
        Receive    = '0;
        repeat (3) step();

        // Reset values
        check("rst_chain_en", 32'(ChainEn), 0);
        check("rst_leg_sel", 32'(LegSel), 0);
        check("rst_radio_valid", 32'(RadioValid), 0);
        check("rst_wire_valid", 32'(WireValid), 0);
        check("rst_radio_data", 32'(RadioData), 0);
        check("rst_wire_data", 32'(WireData), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_dropped", 32'(Dropped), 0);
        Reset_N = 1'b1;
        step();

        // 1/2: single radio request, then single wire request
        run_single(1'b0, 8'hA5);
        run_single(1'b1, 8'h3C);

        // 3: both requests held after reset, grants alternate radio/wire/radio
        do_reset();
        for (int k = 0; k < 3; k++) begin
            legs[k] = ~model_last;
            d = 8'((1 + 6 * k) * 7 + 1);   // Receive value during that FETCH cycle
            push_exp(legs[k], d);
        end
        for (int c = 0; c <= 19; c++) begin
            logic rv;
            logic wv;
            if (c > 0) step();
            rv = 1'b0;
            wv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (c == 5 + 6 * k) begin
                    rv = ~legs[k];
                    wv = legs[k];
                end
            end
            if (c > 0) begin
                check("tie_radio_valid", 32'(RadioValid), 32'(rv));
                check("tie_wire_valid", 32'(WireValid), 32'(wv));
            end
            Receive    = 8'(c * 7 + 1);
            RadioReq   = (c <= 12);
            WireReq    = (c <= 12);
            RadioReady = 1'b1;
            WireReady  = 1'b1;
        end

        // 4: radio backpressure for 10 cycles after Valid
        push_exp(1'b0, 8'h96);
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) step();
            if (c >= 5 && c <= 15) begin
                check("bp_valid", 32'(RadioValid), 1);
                check("bp_data", 32'(RadioData), 32'h96);
            end
            if (c == 16) check("bp_valid_drop", 32'(RadioValid), 0);
            if (c > 0) check("bp_no_drop", 32'(Dropped), 0);
            RadioReq   = (c == 0);
            WireReq    = 1'b0;
            Receive    = 8'h96;
            RadioReady = (c >= 15);
            WireReady  = 1'b1;
        end

`ifdef SPLIT_RADIO_TIMEOUT_EN
        // 5a: radio stalls until timeout, then the pending wire request runs
        model_last = 1'b0;
        push_exp(1'b1, 8'h22);
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) step();
            if (c > 0) begin
                check("to_radio_valid", 32'(RadioValid), 32'(c >= 5 && c <= 19));
                check("to_dropped", 32'(Dropped), 32'(c == 20));
                check("to_wire_valid", 32'(WireValid), 32'(c == 25));
            end
            if (c == 20) check("to_busy_idle", 32'(Busy), 0);
            if (c == 21) begin
                check("to_next_fetch", 32'(ChainEn), 1);
                check("to_next_leg", 32'(LegSel), 1);
            end
            RadioReq   = (c == 0);
            WireReq    = (c >= 1 && c <= 20);
            Receive    = (c <= 1) ? 8'h11 : 8'h22;
            RadioReady = 1'b0;
            WireReady  = 1'b1;
        end

        // 5b: Ready on the last allowed cycle is a normal transfer
        push_exp(1'b0, 8'h5C);
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) step();
            if (c > 0) begin
                check("edge_radio_valid", 32'(RadioValid), 32'(c >= 5 && c <= 19));
                check("edge_dropped", 32'(Dropped), 0);
            end
            if (c == 20) check("edge_busy_idle", 32'(Busy), 0);
            RadioReq   = (c == 0);
            WireReq    = 1'b0;
            Receive    = 8'h5C;
            RadioReady = (c == 19);
            WireReady  = 1'b1;
        end
`endif

        // 6: reset during PROPAGATE aborts with no Valid; tie then goes radio
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) step();
            if (c == 3) begin
                check("mid_rst_chain_en", 32'(ChainEn), 0);
                check("mid_rst_leg_sel", 32'(LegSel), 0);
                check("mid_rst_busy", 32'(Busy), 0);
                check("mid_rst_dropped", 32'(Dropped), 0);
                check("mid_rst_radio_data", 32'(RadioData), 0);
            end
            if (c >= 3) begin
                check("mid_rst_radio_valid", 32'(RadioValid), 0);
                check("mid_rst_wire_valid", 32'(WireValid), 0);
            end
            RadioReq   = (c == 0);
            WireReq    = 1'b0;
            Receive    = 8'h77;
            Reset_N    = (c != 2);
            RadioReady = 1'b1;
            WireReady  = 1'b1;
        end
        model_last = 1'b1;
        legs[0] = ~model_last;
        push_exp(legs[0], 8'h3E);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            if (c == 1) check("post_rst_leg", 32'(LegSel), 32'(legs[0]));
            if (c == 5) begin
                check("post_rst_radio_valid", 32'(RadioValid), 1);
                check("post_rst_wire_valid", 32'(WireValid), 0);
            end
            RadioReq = (c == 0);
            WireReq  = (c == 0);
            Receive  = 8'h3E;
        end

        step();
        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
